// File: rtl/sp_mem_arbiter.sv
// Two-requester round-robin sequencer for one single-port synchronous RAM.
// Requests from A and B are serialised onto a cs/we/oe RAM bus, one access per
// cycle at most. Read data comes back two cycles after the grant and is routed
// to its owner by a two-stage tag pipeline. Out-of-range addresses never select
// the RAM: they are flagged with the grant, writes are dropped, and reads
// return zero.
module sp_mem_arbiter #(
  parameter int WIDTH     = 8,
  parameter int RAM_DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // requester A
  input  logic             a_req_i,
  input  logic             a_we_i,
  input  logic [WIDTH-1:0] a_addr_i,
  input  logic [WIDTH-1:0] a_wdata_i,
  output logic             a_gnt_o,
  output logic             a_rvalid_o,
  output logic [WIDTH-1:0] a_rdata_o,
  output logic             a_err_o,
  // requester B
  input  logic             b_req_i,
  input  logic             b_we_i,
  input  logic [WIDTH-1:0] b_addr_i,
  input  logic [WIDTH-1:0] b_wdata_i,
  output logic             b_gnt_o,
  output logic             b_rvalid_o,
  output logic [WIDTH-1:0] b_rdata_o,
  output logic             b_err_o,
  // RAM bus
  output logic             mem_cs_o,
  output logic             mem_we_o,
  output logic             mem_oe_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_data_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  // The state is the grant register; bit 0 is A's grant, bit 1 is B's grant,
  // so both gnt outputs come straight from flops.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_e;

  // One tag per bus access, following the read data through the RAM latency.
  typedef struct packed {
    logic is_read;
    logic owner_b;
    logic in_range;
  } tag_t;

  localparam logic [WIDTH:0] DEPTH_LIMIT = (WIDTH+1)'(RAM_DEPTH);

  state_e           state_q, state_d;
  logic             ptr_b_q, ptr_b_d;   // 1: B wins the next tie
  logic             elig_a, elig_b;
  logic             a_in_range, b_in_range;

  logic             sel_we;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             sel_in_range;
  tag_t             tag_d, tag1_q, tag2_q;

  logic             mem_cs_q, mem_we_q, mem_oe_q;
  logic [WIDTH-1:0] mem_addr_q, mem_data_q;
  logic             a_err_q, b_err_q;
  logic             a_rvalid_q, b_rvalid_q;
  logic [WIDTH-1:0] a_rdata_q, b_rdata_q;

  // A requester granted this cycle is masked so its still-held req is not
  // granted twice for the same access.
  assign elig_a = a_req_i & ~state_q[0];
  assign elig_b = b_req_i & ~state_q[1];

  assign a_in_range = {1'b0, a_addr_i} < DEPTH_LIMIT;
  assign b_in_range = {1'b0, b_addr_i} < DEPTH_LIMIT;

  // Round-robin grant decision; the pointer moves to the loser after any grant.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    state_d = IDLE;
    ptr_b_d = ptr_b_q;
    if (elig_a && elig_b) begin
      state_d = ptr_b_q ? GNT_B : GNT_A;
    end else if (elig_a) begin
      state_d = GNT_A;
    end else if (elig_b) begin
      state_d = GNT_B;
    end
    if (state_d == GNT_A) begin
      ptr_b_d = 1'b1;
    end else if (state_d == GNT_B) begin
      ptr_b_d = 1'b0;
    end
  end

  // Select the winning requester's command and build its return tag.
  always_comb begin
    sel_we       = a_we_i;
    sel_addr     = a_addr_i;
    sel_wdata    = a_wdata_i;
    sel_in_range = a_in_range;
    if (state_d == GNT_B) begin
      sel_we       = b_we_i;
      sel_addr     = b_addr_i;
      sel_wdata    = b_wdata_i;
      sel_in_range = b_in_range;
    end
    tag_d.is_read  = (state_d != IDLE) && !sel_we;
    tag_d.owner_b  = (state_d == GNT_B);
    tag_d.in_range = sel_in_range;
  end

  // Grant FSM, registered bus outputs, tag pipeline and read-data return.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // sees the values from before this edge regardless of statement order.
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_b_q    <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_oe_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_b_q <= ptr_b_d;

      if (state_d != IDLE) begin
        mem_cs_q   <= sel_in_range;
        mem_we_q   <= sel_we;
        mem_oe_q   <= ~sel_we;
        mem_addr_q <= sel_addr;
        mem_data_q <= sel_wdata;
      end else begin
        // address and data hold their last value while idle
        mem_cs_q <= 1'b0;
        mem_we_q <= 1'b0;
        mem_oe_q <= 1'b0;
      end
      a_err_q <= (state_d == GNT_A) && !sel_in_range;
      b_err_q <= (state_d == GNT_B) && !sel_in_range;

      tag1_q <= tag_d;
      tag2_q <= tag1_q;

      // tag2 lines up with the cycle in which mem_rdata_i is valid
      a_rvalid_q <= tag2_q.is_read && !tag2_q.owner_b;
      b_rvalid_q <= tag2_q.is_read &&  tag2_q.owner_b;
      if (tag2_q.is_read && !tag2_q.owner_b) begin
        a_rdata_q <= tag2_q.in_range ? mem_rdata_i : '0;
      end
      if (tag2_q.is_read && tag2_q.owner_b) begin
        b_rdata_q <= tag2_q.in_range ? mem_rdata_i : '0;
      end
    end
  end

  assign a_gnt_o    = state_q[0];
  assign b_gnt_o    = state_q[1];
  assign a_err_o    = a_err_q;
  assign b_err_o    = b_err_q;
  assign a_rvalid_o = a_rvalid_q;
  assign b_rvalid_o = b_rvalid_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;
  assign mem_cs_o   = mem_cs_q;
  assign mem_we_o   = mem_we_q;
  assign mem_oe_o   = mem_oe_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Bench for sp_mem_arbiter: a behavioural RAM on the bus, a transaction-level
// model of the arbiter compared against every output each cycle, and directed
// scenarios followed by randomized traffic from both requesters.
module tb_sp_mem_arbiter;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_cs, mem_we, mem_oe;
  logic [7:0] mem_addr, mem_data;
  logic [7:0] mem_rdata = 8'h00;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sp_mem_arbiter #(.WIDTH(8), .RAM_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata), .a_err_o(a_err),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err),
    .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_oe_o(mem_oe),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_rdata_i(mem_rdata)
  );

  // Single-port synchronous RAM with a one-cycle registered read.
  logic [7:0] ram [DEPTH] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr[3:0]] <= mem_data;
    if (mem_cs && mem_oe) mem_rdata <= ram[mem_addr[3:0]];
  end

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    int         owner;   // 1 = A, 2 = B
    logic [7:0] data;
  } ret_t;

  ret_t       ret_q[$];
  logic [7:0] mmem [DEPTH] = '{default: 8'h00};
  int         cyc   = 0;
  int         m_gnt = 0;   // who holds the bus this cycle: 0 none, 1 A, 2 B
  int         m_ptr = 0;   // who wins a tie: 0 A, 1 B
  logic       exp_a_gnt = 0, exp_a_rvalid = 0, exp_a_err = 0;
  logic       exp_b_gnt = 0, exp_b_rvalid = 0, exp_b_err = 0;
  logic [7:0] exp_a_rdata = 0, exp_b_rdata = 0;
  logic       exp_cs = 0, exp_we = 0, exp_oe = 0;
  logic [7:0] exp_addr = 0, exp_data = 0;

  string      sig_name [15] = '{"a_gnt", "a_rvalid", "a_rdata", "a_err",
                                "b_gnt", "b_rvalid", "b_rdata", "b_err",
                                "mem_cs", "mem_we", "mem_oe", "mem_addr",
                                "mem_data", "a_rdata_hold", "b_rdata_hold"};

  // Advance one clock: predict what the edge produces from the inputs now
  // applied, then compare every DUT output against the prediction.
  task automatic tick();
    int         c, g;
    bit         ea, eb, we, inr;
    logic [7:0] ad, wd;
    ret_t       r;
    logic [7:0] got [15];
    logic [7:0] expv [15];
    c = cyc + 1;
    if (rst) begin
      m_gnt = 0; m_ptr = 0; ret_q.delete();
      {exp_a_gnt, exp_a_rvalid, exp_a_err, exp_b_gnt, exp_b_rvalid, exp_b_err} = '0;
      {exp_a_rdata, exp_b_rdata, exp_cs, exp_we, exp_oe, exp_addr, exp_data} = '0;
    end else begin
      exp_a_rvalid = 0; exp_b_rvalid = 0;
      while (ret_q.size() > 0 && ret_q[0].due == c) begin
        r = ret_q.pop_front();
        if (r.owner == 1) begin exp_a_rvalid = 1; exp_a_rdata = r.data; end
        else              begin exp_b_rvalid = 1; exp_b_rdata = r.data; end
      end
      ea = a_req && (m_gnt != 1);
      eb = b_req && (m_gnt != 2);
      if (ea && eb)  g = (m_ptr == 0) ? 1 : 2;
      else if (ea)   g = 1;
      else if (eb)   g = 2;
      else           g = 0;
      if (g != 0) m_ptr = (g == 1) ? 1 : 0;
      m_gnt = g;
      exp_a_gnt = (g == 1);
      exp_b_gnt = (g == 2);
      if (g != 0) begin
        ad  = (g == 1) ? a_addr  : b_addr;
        wd  = (g == 1) ? a_wdata : b_wdata;
        we  = (g == 1) ? a_we    : b_we;
        inr = (ad < 8'(DEPTH));
        exp_cs = inr; exp_we = we; exp_oe = !we;
        exp_addr = ad; exp_data = wd;
        exp_a_err = (g == 1) && !inr;
        exp_b_err = (g == 2) && !inr;
        if (we && inr) mmem[ad[3:0]] = wd;
        if (!we) begin
          r.due = c + 2; r.owner = g; r.data = inr ? mmem[ad[3:0]] : 8'h00;
          ret_q.push_back(r);
        end
      end else begin
        exp_cs = 0; exp_we = 0; exp_oe = 0; exp_a_err = 0; exp_b_err = 0;
      end
    end
    @(posedge clk);
    cyc = c;
    #1;
    got  = '{8'(a_gnt), 8'(a_rvalid), a_rdata, 8'(a_err), 8'(b_gnt), 8'(b_rvalid),
             b_rdata, 8'(b_err), 8'(mem_cs), 8'(mem_we), 8'(mem_oe), mem_addr,
             mem_data, a_rdata, b_rdata};
    expv = '{8'(exp_a_gnt), 8'(exp_a_rvalid), exp_a_rdata, 8'(exp_a_err),
             8'(exp_b_gnt), 8'(exp_b_rvalid), exp_b_rdata, 8'(exp_b_err),
             8'(exp_cs), 8'(exp_we), 8'(exp_oe), exp_addr, exp_data,
             exp_a_rdata, exp_b_rdata};
    for (int i = 0; i < 13; i++) begin
      n_total++;
      if (got[i] !== expv[i])
        $display("FAIL cycle %0d %s: got %h expected %h", cyc, sig_name[i], got[i], expv[i]);
      else
        n_pass++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1;
    a_req = 1; a_we = 0; a_addr = 8'd0; a_wdata = 8'h00;
    b_req = 1; b_we = 0; b_addr = 8'd0; b_wdata = 8'h00;
    repeat (3) tick();
    n_total++;
    if ({a_gnt, a_rvalid, a_rdata, a_err, b_gnt, b_rvalid, b_rdata, b_err,
         mem_cs, mem_we, mem_oe, mem_addr, mem_data} !== 49'd0)
      $display("FAIL reset_outputs: got nonzero outputs a_gnt=%b b_gnt=%b mem_cs=%b mem_addr=%h required all zero",
               a_gnt, b_gnt, mem_cs, mem_addr);
    else n_pass++;
    rst = 0;
    tick();
    n_total++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0)
      $display("FAIL first_grant: got a_gnt=%b b_gnt=%b required a_gnt=1 b_gnt=0", a_gnt, b_gnt);
    else n_pass++;
    a_req = 0;
    tick();
    b_req = 0;
    repeat (3) tick();
  endtask

  task automatic test_write_read();
    logic g1, g2;
    a_req = 1; a_we = 1; a_addr = 8'd5; a_wdata = 8'h3C;
    tick();
    for (int i = 0; i < 4 && !exp_a_gnt; i++) tick();
    n_total++;
    if (a_gnt !== 1'b1) $display("FAIL wr_gnt: got a_gnt=%b required 1", a_gnt);
    else n_pass++;
    a_we = 0;
    tick(); g1 = a_gnt;
    tick(); g2 = a_gnt;
    n_total++;
    if ({g1, g2} !== 2'b01)
      $display("FAIL rd_gnt_spacing: got gnt pattern %b required 01", {g1, g2});
    else n_pass++;
    a_req = 0;
    tick();
    n_total++;
    if (a_rvalid !== 1'b0) $display("FAIL rd_early_rvalid: got %b required 0", a_rvalid);
    else n_pass++;
    tick();
    n_total++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'h3C)
      $display("FAIL rd_after_wr: got rvalid=%b rdata=%h required rvalid=1 rdata=3c", a_rvalid, a_rdata);
    else n_pass++;
    n_total++;
    if ({b_gnt, b_rvalid, b_err, b_rdata} !== 11'd0)
      $display("FAIL b_quiet: got b_gnt=%b b_rvalid=%b b_err=%b b_rdata=%h required all 0",
               b_gnt, b_rvalid, b_err, b_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_alternate();
    logic prev_a;
    int   a_gn = 0, b_gn = 0, a_rv = 0, b_rv = 0;
    a_req = 1; a_we = 1; a_addr = 8'd1; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 8'd2; b_wdata = 8'h22;
    tick(); tick();
    prev_a = a_gnt;
    a_we = 0; b_we = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin a_req = 0; b_req = 0; end
      tick();
      if (i < 8) begin
        n_total++;
        if ((a_gnt ^ b_gnt) !== 1'b1 || a_gnt === prev_a)
          $display("FAIL alternate cycle %0d: got a_gnt=%b b_gnt=%b prev_a=%b required alternating",
                   i, a_gnt, b_gnt, prev_a);
        else n_pass++;
        prev_a = a_gnt;
        if (exp_a_gnt) a_gn++;
        if (exp_b_gnt) b_gn++;
      end
      if (a_rvalid === 1'b1) begin
        a_rv++;
        n_total++;
        if (a_rdata !== 8'h11) $display("FAIL alt_a_rdata: got %h required 11", a_rdata);
        else n_pass++;
      end
      if (b_rvalid === 1'b1) begin
        b_rv++;
        n_total++;
        if (b_rdata !== 8'h22) $display("FAIL alt_b_rdata: got %h required 22", b_rdata);
        else n_pass++;
      end
    end
    n_total++;
    if (a_rv != 4 || b_rv != 4 || a_gn != 4 || b_gn != 4)
      $display("FAIL alt_counts: got a_rvalid=%0d b_rvalid=%0d required 4 each", a_rv, b_rv);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    b_req = 1; b_we = 1; b_addr = 8'd20; b_wdata = 8'h77;
    tick();
    for (int i = 0; i < 4 && !exp_b_gnt; i++) tick();
    n_total++;
    if (b_gnt !== 1'b1 || b_err !== 1'b1 || mem_cs !== 1'b0 || a_err !== 1'b0)
      $display("FAIL oor_write: got b_gnt=%b b_err=%b mem_cs=%b required 1 1 0", b_gnt, b_err, mem_cs);
    else n_pass++;
    b_we = 0;
    tick();
    for (int i = 0; i < 4 && !exp_b_gnt; i++) tick();
    n_total++;
    if (b_gnt !== 1'b1 || b_err !== 1'b1 || mem_cs !== 1'b0)
      $display("FAIL oor_read_gnt: got b_gnt=%b b_err=%b mem_cs=%b required 1 1 0", b_gnt, b_err, mem_cs);
    else n_pass++;
    b_req = 0;
    tick(); tick();
    n_total++;
    if (b_rvalid !== 1'b1 || b_rdata !== 8'h00)
      $display("FAIL oor_read_data: got rvalid=%b rdata=%h required rvalid=1 rdata=00", b_rvalid, b_rdata);
    else n_pass++;
    // the dropped write must not have aliased onto word 4
    a_req = 1; a_we = 0; a_addr = 8'd4;
    tick();
    for (int i = 0; i < 4 && !exp_a_gnt; i++) tick();
    a_req = 0;
    tick(); tick();
    n_total++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'h00)
      $display("FAIL oor_no_alias: got rvalid=%b rdata=%h required rvalid=1 rdata=00", a_rvalid, a_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    a_req = 1; a_we = 0; a_addr = 8'd5;
    tick();
    for (int i = 0; i < 4 && !exp_a_gnt; i++) tick();
    a_req = 0;
    tick();
    rst = 1;
    tick();
    n_total++;
    if ({a_gnt, a_rvalid, a_rdata, a_err, b_gnt, b_rvalid, b_rdata, b_err,
         mem_cs, mem_we, mem_oe, mem_addr, mem_data} !== 49'd0)
      $display("FAIL rst_mid_read: got a_rvalid=%b a_rdata=%h mem_addr=%h required all zero",
               a_rvalid, a_rdata, mem_addr);
    else n_pass++;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (a_rvalid !== 1'b0) $display("FAIL rst_late_rvalid: got %b required 0", a_rvalid);
      else n_pass++;
    end
  endtask

  task automatic test_single_hold();
    logic [5:0] pat = '0;
    a_req = 1; a_we = 0; a_addr = 8'd1; b_req = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pat = {pat[4:0], a_gnt};
    end
    n_total++;
    if (pat !== 6'b101010) $display("FAIL hold_mask: got gnt pattern %b required 101010", pat);
    else n_pass++;
    a_req = 0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    bit a_act = 0, b_act = 0;
    a_req = 0; b_req = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (exp_a_gnt) a_act = 0;
      if (a_act && $urandom_range(0, 15) == 0) a_act = 0;
      else if (!a_act && $urandom_range(0, 2) == 0) begin
        a_act = 1; a_we = 1'($urandom_range(0, 1));
        a_addr = 8'($urandom_range(0, 19)); a_wdata = 8'($urandom);
      end
      a_req = a_act;
      if (exp_b_gnt) b_act = 0;
      if (b_act && $urandom_range(0, 15) == 0) b_act = 0;
      else if (!b_act && $urandom_range(0, 2) == 0) begin
        b_act = 1; b_we = 1'($urandom_range(0, 1));
        b_addr = 8'($urandom_range(0, 19)); b_wdata = 8'($urandom);
      end
      b_req = b_act;
    end
    a_req = 0; b_req = 0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_out_of_range();
    test_reset_mid_read();
    test_single_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
